// File: rtl/box_anim_ctrl.sv
// Animation sequencer for the VGA pixel path: clears the screen once, then
// repeatedly draws, holds, erases and moves a bouncing square box.
module box_anim_ctrl #(
   parameter int SCREEN_W        = 160,
   parameter int SCREEN_H        = 120,
   parameter int BOX             = 4,
   parameter int FRAME_TICKS     = 833333,
   parameter int FRAMES_PER_MOVE = 15
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       go,
   input  logic       stop,
   input  logic [2:0] colour_in,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       frame_drawn
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_DRAW, S_WAIT, S_ERASE, S_UPDATE
   } state_t;

   localparam logic [7:0]  X_LAST    = 8'(SCREEN_W - 1);
   localparam logic [6:0]  Y_LAST    = 7'(SCREEN_H - 1);
   localparam logic [7:0]  OX_LAST   = 8'(BOX - 1);
   localparam logic [6:0]  OY_LAST   = 7'(BOX - 1);
   localparam logic [7:0]  X_MAX     = 8'(SCREEN_W - BOX);
   localparam logic [6:0]  Y_MAX     = 7'(SCREEN_H - BOX);
   localparam logic [23:0] DIV_LOAD  = 24'(FRAME_TICKS - 1);
   localparam logic [7:0]  MOVE_LAST = 8'(FRAMES_PER_MOVE - 1);

   state_t      state, state_nx;
   logic [7:0]  cx, ox, bx, bx_nx, x_hold;
   logic [6:0]  cy, oy, by, by_nx, y_hold;
   logic        dx_neg, dy_neg, dx_neg_nx, dy_neg_nx;
   logic [2:0]  box_colour;
   logic [7:0]  tick_cnt;
   logic [23:0] div_cnt;
   logic        tick, clear_done, box_done;

   assign tick       = (div_cnt == 24'd0);
   assign clear_done = (cx == X_LAST) && (cy == Y_LAST);
   assign box_done   = (ox == OX_LAST) && (oy == OY_LAST);

   always_ff @(posedge clock) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:   if (go) state_nx = S_CLEAR;
         S_CLEAR:  if (clear_done) state_nx = S_DRAW;
         S_DRAW:   if (box_done) state_nx = S_WAIT;
         S_WAIT: begin
            if (stop)                                state_nx = S_IDLE;
            else if (tick && tick_cnt == MOVE_LAST)  state_nx = S_ERASE;
         end
         S_ERASE:  if (box_done) state_nx = S_UPDATE;
         S_UPDATE: state_nx = S_DRAW;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Bounce: the box is always in range, so a step out of range only
   // happens at an edge, where reversing means stepping back one pixel.
   always_comb begin
      bx_nx     = bx;
      dx_neg_nx = dx_neg;
      if (X_MAX != 8'd0) begin
         if (!dx_neg) begin
            if (bx == X_MAX) begin dx_neg_nx = 1'b1; bx_nx = bx - 8'd1; end
            else             bx_nx = bx + 8'd1;
         end else begin
            if (bx == 8'd0)  begin dx_neg_nx = 1'b0; bx_nx = 8'd1; end
            else             bx_nx = bx - 8'd1;
         end
      end
      by_nx     = by;
      dy_neg_nx = dy_neg;
      if (Y_MAX != 7'd0) begin
         if (!dy_neg) begin
            if (by == Y_MAX) begin dy_neg_nx = 1'b1; by_nx = by - 7'd1; end
            else             by_nx = by + 7'd1;
         end else begin
            if (by == 7'd0)  begin dy_neg_nx = 1'b0; by_nx = 7'd1; end
            else             by_nx = by - 7'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n || tick) div_cnt <= DIV_LOAD;
      else                  div_cnt <= div_cnt - 24'd1;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cx          <= '0;
         cy          <= '0;
         ox          <= '0;
         oy          <= '0;
         bx          <= '0;
         by          <= '0;
         dx_neg      <= 1'b0;
         dy_neg      <= 1'b0;
         box_colour  <= '0;
         tick_cnt    <= '0;
         x_hold      <= '0;
         y_hold      <= '0;
         frame_drawn <= 1'b0;
      end else begin
         frame_drawn <= (state == S_DRAW) && box_done;
         if (plot) begin
            x_hold <= x;
            y_hold <= y;
         end
         unique case (state)
            S_IDLE: if (go) begin
               box_colour <= colour_in;
               bx         <= '0;
               by         <= '0;
               dx_neg     <= 1'b0;
               dy_neg     <= 1'b0;
               cx         <= '0;
               cy         <= '0;
            end
            S_CLEAR: begin
               if (cx == X_LAST) begin
                  cx <= '0;
                  cy <= clear_done ? 7'd0 : cy + 7'd1;
                  ox <= '0;
                  oy <= '0;
               end else begin
                  cx <= cx + 8'd1;
               end
            end
            S_DRAW, S_ERASE: begin
               if (ox == OX_LAST) begin
                  ox <= '0;
                  oy <= box_done ? 7'd0 : oy + 7'd1;
               end else begin
                  ox <= ox + 8'd1;
               end
               if (box_done) tick_cnt <= '0;
            end
            S_WAIT: if (tick) tick_cnt <= tick_cnt + 8'd1;
            S_UPDATE: begin
               bx     <= bx_nx;
               by     <= by_nx;
               dx_neg <= dx_neg_nx;
               dy_neg <= dy_neg_nx;
            end
            default: ;
         endcase
      end
   end

   // x/y hold the last plotted pixel while idle so they never leave the screen.
   always_comb begin
      plot   = 1'b0;
      x      = x_hold;
      y      = y_hold;
      colour = 3'd0;
      busy   = (state != S_IDLE);
      unique case (state)
         S_CLEAR: begin
            plot = 1'b1;
            x    = cx;
            y    = cy;
         end
         S_DRAW, S_ERASE: begin
            plot   = 1'b1;
            x      = bx + ox;
            y      = by + oy;
            colour = (state == S_DRAW) ? box_colour : 3'd0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_box_anim_ctrl.sv
// Directed bench for box_anim_ctrl on an 8x6 screen with a 2x2 box.
module tb_box_anim_ctrl;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       go = 1'b0;
   logic       stop = 1'b0;
   logic [2:0] colour_in = 3'd0;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot, busy, frame_drawn;

   int n_total = 0;
   int n_bad   = 0;
   int wlen    = 0;
   int n       = 0;

   // Box top-left at each DRAW, hand-derived from the bounce rule.
   int px[14] = '{0, 1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 0, 1};
   int py[14] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4, 3};

   always #5 clock = ~clock;

   box_anim_ctrl #(
      .SCREEN_W(8), .SCREEN_H(6), .BOX(2), .FRAME_TICKS(4), .FRAMES_PER_MOVE(1)
   ) dut (
      .clock(clock), .reset_n(reset_n), .go(go), .stop(stop), .colour_in(colour_in),
      .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .frame_drawn(frame_drawn)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_clear();
      for (int i = 0; i < 48; i++) begin
         check_eq("clr_plot", 32'(plot), 1);
         check_eq("clr_colour", 32'(colour), 0);
         check_eq("clr_x", 32'(x), i % 8);
         check_eq("clr_y", 32'(y), i / 8);
         step();
      end
   endtask

   task automatic expect_box(input int bx, input int by, input int col);
      for (int oy = 0; oy < 2; oy++) begin
         for (int ox = 0; ox < 2; ox++) begin
            check_eq("box_plot", 32'(plot), 1);
            check_eq("box_colour", 32'(colour), col);
            check_eq("box_x", 32'(x), bx + ox);
            check_eq("box_y", 32'(y), by + oy);
            check_eq("box_busy", 32'(busy), 1);
            step();
         end
      end
   endtask

   task automatic wait_plot(output int cnt);
      cnt = 0;
      while (plot !== 1'b1 && cnt < 20) begin
         step();
         cnt++;
      end
      check_eq("wait_plot", 32'(plot), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      step();
      step();
      check_eq("rst_plot", 32'(plot), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_x", 32'(x), 0);
      check_eq("rst_y", 32'(y), 0);
      check_eq("rst_colour", 32'(colour), 0);
      check_eq("rst_frame", 32'(frame_drawn), 0);
      reset_n = 1'b1;
      step();
      check_eq("idle_busy", 32'(busy), 0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check_eq("idle_stop_busy", 32'(busy), 0);

      // Clear then first draw
      go = 1'b1;
      colour_in = 3'b100;
      step();
      go = 1'b0;
      colour_in = 3'd0;
      expect_clear();
      expect_box(0, 0, 4);
      check_eq("fd_pulse", 32'(frame_drawn), 1);
      check_eq("wait_plot0", 32'(plot), 0);
      check_eq("wait_busy", 32'(busy), 1);
      step();
      check_eq("fd_single", 32'(frame_drawn), 0);

      // Erase / update / redraw cycles with bouncing; go+colour_in ignored while busy
      for (int k = 1; k < 14; k++) begin
         if (k == 2) begin
            go = 1'b1;
            colour_in = 3'b010;
         end
         wait_plot(n);
         wlen = n;
         expect_box(px[k-1], py[k-1], 0);
         check_eq("upd_plot", 32'(plot), 0);
         check_eq("upd_busy", 32'(busy), 1);
         step();
         expect_box(px[k], py[k], 4);
         check_eq("loop_fd", 32'(frame_drawn), 1);
         check_eq("loop_wait_plot", 32'(plot), 0);
         if (k == 3) begin
            go = 1'b0;
            colour_in = 3'd0;
         end
      end
      check_eq("wait_len", wlen, 3);

      // Stop on the WAIT cycle that carries the tick, with go also high
      for (int j = 0; j < wlen - 1; j++) step();
      stop = 1'b1;
      go = 1'b1;
      step();
      stop = 1'b0;
      go = 1'b0;
      check_eq("stop_busy", 32'(busy), 0);
      check_eq("stop_plot", 32'(plot), 0);
      check_eq("stop_x_hold", 32'(x), 2);
      check_eq("stop_y_hold", 32'(y), 4);
      for (int j = 0; j < 6; j++) begin
         check_eq("stop_no_erase", 32'(plot), 0);
         step();
      end

      // Restart after stop
      go = 1'b1;
      colour_in = 3'b010;
      step();
      go = 1'b0;
      expect_clear();
      expect_box(0, 0, 2);
      check_eq("restart_fd", 32'(frame_drawn), 1);

      // Reset in the middle of CLEAR
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      go = 1'b1;
      colour_in = 3'b001;
      step();
      go = 1'b0;
      for (int j = 0; j < 19; j++) step();
      check_eq("mid_x", 32'(x), 3);
      check_eq("mid_y", 32'(y), 2);
      check_eq("mid_plot", 32'(plot), 1);
      reset_n = 1'b0;
      step();
      check_eq("mrst_plot", 32'(plot), 0);
      check_eq("mrst_busy", 32'(busy), 0);
      check_eq("mrst_x", 32'(x), 0);
      check_eq("mrst_y", 32'(y), 0);
      reset_n = 1'b1;
      go = 1'b1;
      step();
      go = 1'b0;
      expect_clear();
      expect_box(0, 0, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
